// File: rtl/mem_load_unit_pkg.sv
// Shared definitions for the M-stage load unit: load op codes, bus size codes,
// FSM state encoding and small op-decoding helpers.
package mem_load_unit_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        LDU_IDLE   = 3'd0,
        LDU_REQ    = 3'd1,
        LDU_WAIT   = 3'd2,
        LDU_DONE   = 3'd3,
        LDU_CANCEL = 3'd4
    } ldu_state_e;

    function automatic logic is_load_op(input logic [7:0] op_i);
        logic r;
        case (op_i)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op_i);
        logic [1:0] r;
        case (op_i)
            EXE_LH_OP, EXE_LHU_OP: r = SIZE_HALF;
            EXE_LW_OP:             r = SIZE_WORD;
            default:               r = SIZE_BYTE;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op_i, input logic [1:0] addr_lo);
        logic r;
        case (op_i)
            EXE_LH_OP, EXE_LHU_OP: r = addr_lo[0];
            EXE_LW_OP:             r = (addr_lo != 2'b00);
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// Data-side SRAM-like read bus between the load unit (master) and memory (slave).
interface mem_load_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_load_unit_load_extend.sv
// Little-endian lane selection and sign/zero extension of a returned load word.
module load_extend
    import mem_load_unit_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [7:0]    op,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte/half lane and extend it according to the op
    always_comb begin
        byte_s = 8'd0;
        half_s = 16'd0;
        ext    = '0;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'd0;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (op)
            EXE_LB_OP:  ext = {{(DW-8){byte_s[7]}}, byte_s};
            EXE_LBU_OP: ext = {{(DW-8){1'b0}}, byte_s};
            EXE_LH_OP:  ext = {{(DW-16){half_s[15]}}, half_s};
            EXE_LHU_OP: ext = {{(DW-16){1'b0}}, half_s};
            EXE_LW_OP:  ext = rdata;
            default:    ext = '0;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// M-stage load engine: issues one read on the data bus per load, stalls the
// pipeline until data returns and holds the extended result until advance.
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                load_valid,
    input  logic [7:0]          op,
    input  logic [AW-1:0]       addr,
    input  logic                flush,
    input  logic                advance,
    mem_load_unit_if.master     bus,
    output logic                stall,
    output logic [DW-1:0]       result,
    output logic                result_valid,
    output logic                adel,
    output logic [AW-1:0]       badvaddr
);

    ldu_state_e    state_r;
    ldu_state_e    state_next_s;
    logic [7:0]    op_r;
    logic [1:0]    data_size_r;
    logic [AW-1:0] data_addr_r;
    logic          data_req_r;
    logic [DW-1:0] result_r;
    logic          result_valid_r;
    logic          adel_s;
    logic          accept_s;
    logic [DW-1:0] ext_s;

    load_extend #(.DW(DW)) u_load_extend (
        .op      (op_r),
        .addr_lo (data_addr_r[1:0]),
        .rdata   (bus.data_rdata),
        .ext     (ext_s)
    );

    // Misalignment detection and acceptance of a new load in IDLE
    always_comb begin
        adel_s   = load_valid & is_misaligned(op, addr[1:0]);
        accept_s = (state_r == LDU_IDLE) & load_valid & is_load_op(op) & ~adel_s & ~flush;
    end

    // Next-state logic; a transaction accepted by the bus is always drained via CANCEL
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LDU_IDLE: begin
                if (accept_s) begin
                    state_next_s = LDU_REQ;
                end else begin
                    state_next_s = LDU_IDLE;
                end
            end
            LDU_REQ: begin
                if (bus.data_addr_ok) begin
                    state_next_s = flush ? LDU_CANCEL : LDU_WAIT;
                end else begin
                    state_next_s = flush ? LDU_IDLE : LDU_REQ;
                end
            end
            LDU_WAIT: begin
                if (bus.data_data_ok) begin
                    state_next_s = flush ? LDU_IDLE : LDU_DONE;
                end else begin
                    state_next_s = flush ? LDU_CANCEL : LDU_WAIT;
                end
            end
            LDU_DONE: begin
                if (advance | flush) begin
                    state_next_s = LDU_IDLE;
                end else begin
                    state_next_s = LDU_DONE;
                end
            end
            LDU_CANCEL: begin
                if (bus.data_data_ok) begin
                    state_next_s = LDU_IDLE;
                end else begin
                    state_next_s = LDU_CANCEL;
                end
            end
            default: state_next_s = LDU_IDLE;
        endcase
    end

    // State, request latch and result registers; result is zero outside DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= LDU_IDLE;
            op_r           <= 8'd0;
            data_size_r    <= 2'd0;
            data_addr_r    <= '0;
            data_req_r     <= 1'b0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            data_req_r     <= (state_next_s == LDU_REQ);
            result_valid_r <= (state_next_s == LDU_DONE);
            if (accept_s) begin
                op_r        <= op;
                data_addr_r <= addr;
                data_size_r <= op_size(op);
            end else begin
                op_r        <= op_r;
                data_addr_r <= data_addr_r;
                data_size_r <= data_size_r;
            end
            if (state_next_s == LDU_DONE) begin
                result_r <= (state_r == LDU_WAIT) ? ext_s : result_r;
            end else begin
                result_r <= '0;
            end
        end
    end

    // Output mapping
    always_comb begin
        bus.data_req  = data_req_r;
        bus.data_wr   = 1'b0;
        bus.data_size = data_size_r;
        bus.data_addr = data_addr_r;
        result        = result_r;
        result_valid  = result_valid_r;
        adel          = adel_s;
        badvaddr      = adel_s ? addr : '0;
        stall         = accept_s | (state_r == LDU_REQ) | (state_r == LDU_WAIT) |
                        (state_r == LDU_CANCEL);
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: reference model of load results, a reactive
// bus responder and a per-cycle compare process.
module tb_mem_load_unit;
    import mem_load_unit_pkg::*;

    logic        clk;
    logic        resetn;
    logic        load_valid;
    logic [7:0]  op;
    logic [31:0] addr;
    logic        flush;
    logic        advance;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic        adel;
    logic [31:0] badvaddr;

    mem_load_unit_if #(.AW(32), .DW(32)) bus ();

    mem_load_unit #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .load_valid   (load_valid),
        .op           (op),
        .addr         (addr),
        .flush        (flush),
        .advance      (advance),
        .bus          (bus.master),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid),
        .adel         (adel),
        .badvaddr     (badvaddr)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0]  exp_op    = 8'd0;
    logic [31:0] exp_addr  = 32'd0;
    logic [31:0] exp_rdata = 32'd0;
    int          addr_lat  = 0;
    int          data_lat  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: what a load must return, computed arithmetically
    function automatic logic [31:0] model_load(input logic [7:0] o, input logic [31:0] a,
                                               input logic [31:0] d);
        longint v;
        int     sh8;
        int     sh16;
        sh8  = 8 * int'(a % 4);
        sh16 = 16 * int'((a % 4) / 2);
        v = 0;
        if (o == EXE_LB_OP || o == EXE_LBU_OP) begin
            v = longint'((d >> sh8) % 256);
            if (o == EXE_LB_OP && v > 127) v = v - 256;
        end else if (o == EXE_LH_OP || o == EXE_LHU_OP) begin
            v = longint'((d >> sh16) % 65536);
            if (o == EXE_LH_OP && v > 32767) v = v - 65536;
        end else if (o == EXE_LW_OP) begin
            v = longint'(d);
        end
        return v[31:0];
    endfunction

    function automatic logic [1:0] model_size(input logic [7:0] o);
        if (o == EXE_LW_OP) return 2'd2;
        if (o == EXE_LH_OP || o == EXE_LHU_OP) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic model_adel(input logic lv, input logic [7:0] o, input logic [31:0] a);
        int align;
        align = 1;
        if (o == EXE_LH_OP || o == EXE_LHU_OP) align = 2;
        if (o == EXE_LW_OP) align = 4;
        return lv && ((a % align) != 0);
    endfunction

    // Bus responder: addr_ok after addr_lat cycles of request, data_ok data_lat cycles later
    initial begin
        bit pend;
        int a_cnt;
        int d_cnt;
        pend = 0; a_cnt = 0; d_cnt = 0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            bus.data_rdata   = 32'hDEAD_BEEF;
            if (!resetn) begin
                pend = 0; a_cnt = 0;
            end else if (pend) begin
                if (d_cnt == 0) begin
                    bus.data_data_ok = 1'b1;
                    bus.data_rdata   = exp_rdata;
                    pend = 0;
                end else begin
                    d_cnt--;
                end
            end else if (bus.data_req) begin
                if (a_cnt >= addr_lat) begin
                    bus.data_addr_ok = 1'b1;
                    pend = 1; d_cnt = data_lat; a_cnt = 0;
                end else begin
                    a_cnt++;
                end
            end else begin
                a_cnt = 0;
            end
        end
    end

    // Per-cycle compare against the model
    logic        prev_req = 1'b0, prev_aok = 1'b0, prev_flush = 1'b0, prev_rstn = 1'b0;
    logic [31:0] prev_daddr = 32'd0;
    logic [1:0]  prev_size = 2'd0;
    always @(negedge clk) begin
        logic e_adel;
        e_adel = model_adel(load_valid, op, addr);
        check("adel", {31'd0, adel}, {31'd0, e_adel});
        check("badvaddr", badvaddr, e_adel ? addr : 32'd0);
        check("data_wr", {31'd0, bus.data_wr}, 32'd0);
        if (resetn) begin
            if (bus.data_req) begin
                check("data_addr", bus.data_addr, exp_addr);
                check("data_size", {30'd0, bus.data_size}, {30'd0, model_size(exp_op)});
            end
            if (prev_rstn && prev_req && !prev_aok && !prev_flush) begin
                check("req_held", {31'd0, bus.data_req}, 32'd1);
                check("req_addr_stable", bus.data_addr, prev_daddr);
                check("req_size_stable", {30'd0, bus.data_size}, {30'd0, prev_size});
            end
            if (result_valid) begin
                check("result", result, model_load(exp_op, exp_addr, exp_rdata));
                check("stall_in_done", {31'd0, stall}, 32'd0);
            end else begin
                check("result_idle", result, 32'd0);
            end
        end
        prev_req   = bus.data_req;
        prev_aok   = bus.data_addr_ok;
        prev_flush = flush;
        prev_rstn  = resetn;
        prev_daddr = bus.data_addr;
        prev_size  = bus.data_size;
    end

    task automatic run_load(input logic [7:0] o, input logic [31:0] a, input logic [31:0] d,
                            input int al, input int dl, input int hold,
                            output int stalls, output int reqs, output logic [1:0] sz,
                            output logic [31:0] res);
        bit got;
        exp_op = o; exp_addr = a; exp_rdata = d; addr_lat = al; data_lat = dl;
        @(posedge clk);
        #1;
        load_valid = 1'b1; op = o; addr = a;
        stalls = 0; reqs = 0; sz = 2'd3; res = 32'd0; got = 0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (bus.data_req) begin
                reqs++;
                sz = bus.data_size;
            end
            if (result_valid) begin
                got = 1;
                res = result;
            end
        end
        check("result_valid_seen", {31'd0, got}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, result_valid}, 32'd1);
            check("hold_result", result, model_load(o, a, d));
        end
        advance = 1'b1;
        @(posedge clk);
        #1;
        advance = 1'b0; load_valid = 1'b0; op = 8'd0;
        @(negedge clk);
        check("rv_after_advance", {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        int          st;
        int          rq;
        logic [1:0]  sz;
        logic [31:0] res;
        bit          rv_seen;
        int          idle_at;

        resetn = 1'b0; load_valid = 1'b0; op = 8'd0; addr = 32'd0;
        flush = 1'b0; advance = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_req", {31'd0, bus.data_req}, 32'd0);
        check("rst_data_size", {30'd0, bus.data_size}, 32'd0);
        check("rst_data_addr", bus.data_addr, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        resetn = 1'b1;

        // LB sign-extend, zero-wait bus
        run_load(EXE_LB_OP, 32'h1003, 32'h80FF_1234, 0, 0, 0, st, rq, sz, res);
        check("lb_result", res, 32'hFFFF_FF80);
        check("lb_stall_cycles", st, 32'd3);
        check("lb_req_cycles", rq, 32'd1);
        check("lb_size", {30'd0, sz}, 32'd0);

        // LHU with wait states
        run_load(EXE_LHU_OP, 32'h2002, 32'hBEEF_0000, 2, 3, 0, st, rq, sz, res);
        check("lhu_result", res, 32'h0000_BEEF);
        check("lhu_req_cycles", rq, 32'd3);
        check("lhu_stall_cycles", st, 32'd8);
        check("lhu_size", {30'd0, sz}, 32'd1);

        // Misaligned LW
        exp_op = EXE_LW_OP; exp_addr = 32'h3001;
        @(posedge clk);
        #1;
        load_valid = 1'b1; op = EXE_LW_OP; addr = 32'h3001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("adel_flag", {31'd0, adel}, 32'd1);
            check("adel_badvaddr", badvaddr, 32'h3001);
            check("adel_no_req", {31'd0, bus.data_req}, 32'd0);
            check("adel_no_stall", {31'd0, stall}, 32'd0);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0; op = 8'd0; addr = 32'd0;

        // Non-load op is ignored
        @(posedge clk);
        #1;
        load_valid = 1'b1; op = 8'h21; addr = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("nonload_stall", {31'd0, stall}, 32'd0);
            check("nonload_req", {31'd0, bus.data_req}, 32'd0);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0; op = 8'd0;

        // LW flushed in WAIT; the late data_ok must be absorbed
        exp_op = EXE_LW_OP; exp_addr = 32'h40; exp_rdata = 32'hCAFE_F00D;
        addr_lat = 0; data_lat = 2;
        @(posedge clk);
        #1;
        load_valid = 1'b1; op = EXE_LW_OP; addr = 32'h40;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1; load_valid = 1'b0;
        @(negedge clk);
        check("flush_wait_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        rv_seen = 0; idle_at = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (result_valid) rv_seen = 1;
            if (!stall && idle_at < 0) idle_at = c;
        end
        check("cancel_no_result", {31'd0, rv_seen}, 32'd0);
        check("cancel_release", idle_at, 32'd2);
        run_load(EXE_LW_OP, 32'h44, 32'h1234_5678, 0, 0, 0, st, rq, sz, res);
        check("lw_after_cancel", res, 32'h1234_5678);
        check("lw_after_cancel_stall", st, 32'd3);

        // LH held for several cycles without advance
        run_load(EXE_LH_OP, 32'h10, 32'h0000_7FFF, 0, 0, 4, st, rq, sz, res);
        check("lh_result", res, 32'h0000_7FFF);
        run_load(EXE_LH_OP, 32'h12, 32'h80FF_1234, 1, 1, 0, st, rq, sz, res);
        check("lh_neg_result", res, 32'hFFFF_80FF);
        run_load(EXE_LBU_OP, 32'h1001, 32'h80FF_1234, 0, 0, 0, st, rq, sz, res);
        check("lbu_result", res, 32'h0000_0012);

        // Asynchronous reset while in WAIT
        exp_op = EXE_LW_OP; exp_addr = 32'h50; exp_rdata = 32'h5555_AAAA;
        addr_lat = 0; data_lat = 5;
        @(posedge clk);
        #1;
        load_valid = 1'b1; op = EXE_LW_OP; addr = 32'h50;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_stall", {31'd0, stall}, 32'd1);
        #2;
        resetn = 1'b0; load_valid = 1'b0; op = 8'd0;
        #1;
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_data_req", {31'd0, bus.data_req}, 32'd0);
        check("arst_data_addr", bus.data_addr, 32'd0);
        check("arst_data_size", {30'd0, bus.data_size}, 32'd0);
        check("arst_result_valid", {31'd0, result_valid}, 32'd0);
        check("arst_result", result, 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        run_load(EXE_LBU_OP, 32'h60, 32'h1234_56AB, 0, 0, 0, st, rq, sz, res);
        check("lbu_after_reset", res, 32'h0000_00AB);
        check("lbu_after_reset_stall", st, 32'd3);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
